// File: rtl/subsurf_pkg.sv
// Shared types and constants for the subsurf memory subsystem.
package subsurf_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int WE_WIDTH   = 4;
    localparam int CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;
endpackage

// File: rtl/subsurf_if.sv
// Host load/readback bus: one request per cycle, read data one cycle later.
interface subsurf_host_if #(
    parameter int BW         = 2,
    parameter int ADDR_WIDTH = 11
);
    import subsurf_pkg::*;

    logic                  req;
    logic                  we;
    logic [WE_WIDTH-1:0]   be;
    logic [BW-1:0]         bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  err;

    modport master (output req, we, be, bank, addr, wdata,
                    input  ready, rdata, rvalid, err);
    modport slave  (input  req, we, be, bank, addr, wdata,
                    output ready, rdata, rvalid, err);
endinterface

// File: rtl/quadram.sv
// Single-port word RAM with byte write enables and a registered read port.
module quadram
    import subsurf_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WE_WIDTH-1:0]   we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Byte-masked write; contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < WE_WIDTH; b++) begin
                if (we[b]) mem[addr][b*8 +: 8] <= di[b*8 +: 8];
            end
        end
    end

    // Read-before-write output register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     dout <= '0;
        else if (en) dout <= mem[addr];
    end
endmodule

// File: rtl/subsurf_run_ctrl.sv
// Run FSM: hands banks to the engine, tracks busy/watchdog, reports run length.
module subsurf_run_ctrl
    import subsurf_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 eng_busy,
    output logic                 host_owns,
    output logic                 eng_start,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] run_cycles
);
    run_state_t           state;
    logic                 seen_busy;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 normal_end;
    logic                 wd_fire;

    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign normal_end = seen_busy & ~eng_busy;
    assign wd_fire    = (TIMEOUT_CYCLES != 0) && (cnt >= CNT_WIDTH'(TIMEOUT_CYCLES));

    assign host_owns = (state == IDLE) || (state == DONE);
    assign eng_start = (state == START);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State walk, busy tracking, saturating run counter and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            seen_busy  <= 1'b0;
            cnt        <= '0;
            timeout    <= 1'b0;
            run_cycles <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= START;
                    cnt     <= '0;
                    timeout <= 1'b0;
                end
                START: begin
                    seen_busy <= 1'b0;
                    cnt       <= cnt_inc;
                    state     <= RUN;
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (eng_busy) seen_busy <= 1'b1;
                    if (normal_end) begin
                        state      <= DONE;
                        run_cycles <= cnt_inc;
                    end else if (wd_fire) begin
                        state      <= DONE;
                        timeout    <= 1'b1;
                        run_cycles <= cnt_inc;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/subsurf_mem_system.sv
// Banked quadram subsystem shared between the host port and the subsurf engine.
module subsurf_mem_system
    import subsurf_pkg::*;
#(
    parameter int NUM_BANKS      = 3,
    parameter int ADDR_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [CNT_WIDTH-1:0]             run_cycles,
    subsurf_host_if.slave                    host,
    output logic                             eng_start,
    input  logic                             eng_busy,
    input  logic [NUM_BANKS-1:0]             eng_en,
    input  logic [WE_WIDTH*NUM_BANKS-1:0]    eng_we,
    input  logic [ADDR_WIDTH*NUM_BANKS-1:0]  eng_addr,
    input  logic [DATA_WIDTH*NUM_BANKS-1:0]  eng_di,
    output logic [DATA_WIDTH*NUM_BANKS-1:0]  eng_do
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                                 host_owns;
    logic                                 host_acc;
    logic                                 oob;
    logic [BW-1:0]                        bank_w;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] ram_do;

    logic                                 vld_pipe;
    logic [BW-1:0]                        rd_bank;
    logic                                 rd_oob;
    logic                                 err_q;
    logic [DATA_WIDTH-1:0]                rdata_hold;
    logic [DATA_WIDTH-1:0]                rd_data_now;

    subsurf_run_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .eng_busy   (eng_busy),
        .host_owns  (host_owns),
        .eng_start  (eng_start),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .run_cycles (run_cycles)
    );

    assign bank_w     = BW'(host.bank);
    assign host.ready = host_owns & ~rst;
    assign host_acc   = host.req & host.ready;
    assign oob        = (32'(bank_w) >= NUM_BANKS);

    // Per-bank ownership mux; the non-owner is held inactive, no extra register.
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic                  hsel;
        logic                  en;
        logic [WE_WIDTH-1:0]   we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] di;

        assign hsel = host_acc & ~oob & (bank_w == BW'(i));
        assign en   = host_owns ? hsel : eng_en[i];
        assign we   = host_owns ? ((hsel & host.we) ? host.be : '0)
                                : (eng_en[i] ? eng_we[i*WE_WIDTH +: WE_WIDTH] : '0);
        assign addr = host_owns ? host.addr  : eng_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign di   = host_owns ? host.wdata : eng_di[i*DATA_WIDTH +: DATA_WIDTH];

        quadram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .we   (we),
            .addr (addr),
            .di   (di),
            .dout (ram_do[i])
        );
    end

    assign eng_do = ram_do;

    // Returning read data: live from the RAM on the return cycle, held after.
    assign rd_data_now = rd_oob ? '0 : ram_do[rd_bank];
    assign host.rvalid = vld_pipe;
    assign host.rdata  = vld_pipe ? rd_data_now : rdata_hold;
    assign host.err    = err_q;

    // Track the in-flight host read and capture its data for holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= 1'b0;
            rd_bank    <= '0;
            rd_oob     <= 1'b0;
            err_q      <= 1'b0;
            rdata_hold <= '0;
        end else begin
            vld_pipe <= host_acc & ~host.we;
            rd_bank  <= bank_w;
            rd_oob   <= oob;
            err_q    <= host_acc & oob;
            if (vld_pipe) rdata_hold <= rd_data_now;
        end
    end
endmodule
